// File: rtl/mem_read_arbiter_if.sv
// Bus bundle between the fetch/load-store requesters, the read arbiter and the
// shared program memory.
//   if_* : fetch port   (req/addr in, gnt/rvalid/rdata/err out of the arbiter)
//   ls_* : load port    (same shape as the fetch port)
//   mem_addr / mem_dout : byte address to memory, combinational read data back
//   busy : arbiter has an access in flight
// Modports: slave = arbiter side, master = requesters plus memory model.
interface mem_read_arbiter_if #(
   parameter int unsigned N = 32
);
   logic         if_req;
   logic [N-1:0] if_addr;
   logic         if_gnt;
   logic         if_rvalid;
   logic [N-1:0] if_rdata;
   logic         if_err;

   logic         ls_req;
   logic [N-1:0] ls_addr;
   logic         ls_gnt;
   logic         ls_rvalid;
   logic [N-1:0] ls_rdata;
   logic         ls_err;

   logic [N-1:0] mem_addr;
   logic [N-1:0] mem_dout;
   logic         busy;

   modport slave (
      input  if_req, if_addr, ls_req, ls_addr, mem_dout,
      output if_gnt, if_rvalid, if_rdata, if_err,
      output ls_gnt, ls_rvalid, ls_rdata, ls_err,
      output mem_addr, busy
   );

   modport master (
      output if_req, if_addr, ls_req, ls_addr, mem_dout,
      input  if_gnt, if_rvalid, if_rdata, if_err,
      input  ls_gnt, ls_rvalid, ls_rdata, ls_err,
      input  mem_addr, busy
   );
endinterface

// File: rtl/mem_read_arbiter.sv
// Two-port round-robin arbiter/sequencer for the shared read-only program memory.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : mem_read_arbiter_if.slave -- fetch and load request ports, memory
//           address/data, busy flag
// Each access takes two edges: IDLE latches the winner's address (gnt pulses),
// READ captures the memory word (rvalid pulses). All outputs are registered.
module mem_read_arbiter #(
   parameter int unsigned N     = 32,
   parameter int unsigned WIDTH = 9
) (
   input logic               clk,
   input logic               rst_n,
   mem_read_arbiter_if.slave bus
);

   typedef enum logic [0:0] {StIdle, StRead} state_e;

   state_e       state_q;
   logic         last_ls_q;   // last_owner: 1 = LS, 0 = IF
   logic         owner_ls_q;  // owner of the access in flight
   logic [N-1:0] mem_addr_q;
   logic         if_gnt_q, ls_gnt_q;
   logic         if_rvalid_q, ls_rvalid_q;
   logic [N-1:0] if_rdata_q, ls_rdata_q;
   logic         if_err_q, ls_err_q;
   logic         busy_q;

   logic         win_ls;
   logic         addr_err;
   logic [N-1:0] rd_word;

   // LS wins when it is alone, or on a tie when IF owned the previous access.
   assign win_ls   = bus.ls_req && !(bus.if_req && last_ls_q);
   assign addr_err = (mem_addr_q[1:0] != 2'b00) || (mem_addr_q[N-1:WIDTH+2] != '0);
   assign rd_word  = addr_err ? '0 : bus.mem_dout;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= StIdle;
         last_ls_q   <= 1'b1;
         owner_ls_q  <= 1'b0;
         mem_addr_q  <= '0;
         if_gnt_q    <= 1'b0;
         ls_gnt_q    <= 1'b0;
         if_rvalid_q <= 1'b0;
         ls_rvalid_q <= 1'b0;
         if_rdata_q  <= '0;
         ls_rdata_q  <= '0;
         if_err_q    <= 1'b0;
         ls_err_q    <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         if_gnt_q    <= 1'b0;
         ls_gnt_q    <= 1'b0;
         if_rvalid_q <= 1'b0;
         ls_rvalid_q <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (bus.if_req || bus.ls_req) begin
                  mem_addr_q <= win_ls ? bus.ls_addr : bus.if_addr;
                  owner_ls_q <= win_ls;
                  last_ls_q  <= win_ls;
                  if_gnt_q   <= !win_ls;
                  ls_gnt_q   <= win_ls;
                  busy_q     <= 1'b1;
                  state_q    <= StRead;
               end
            end
            StRead: begin
               // Memory is still driven with a bad address; the word is dropped.
               if (owner_ls_q) begin
                  ls_rvalid_q <= 1'b1;
                  ls_err_q    <= addr_err;
                  ls_rdata_q  <= rd_word;
               end else begin
                  if_rvalid_q <= 1'b1;
                  if_err_q    <= addr_err;
                  if_rdata_q  <= rd_word;
               end
               busy_q  <= 1'b0;
               state_q <= StIdle;
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign bus.if_gnt    = if_gnt_q;
   assign bus.ls_gnt    = ls_gnt_q;
   assign bus.if_rvalid = if_rvalid_q;
   assign bus.ls_rvalid = ls_rvalid_q;
   assign bus.if_rdata  = if_rdata_q;
   assign bus.ls_rdata  = ls_rdata_q;
   assign bus.if_err    = if_err_q;
   assign bus.ls_err    = ls_err_q;
   assign bus.mem_addr  = mem_addr_q;
   assign bus.busy      = busy_q;

endmodule

// File: tb/tb_mem_read_arbiter.sv
// Bench for mem_read_arbiter: directed stimulus, a transaction-level model that
// is compared against every output on every falling edge, plus literal checks.
module tb_mem_read_arbiter;

   localparam int unsigned N     = 32;
   localparam int unsigned WIDTH = 9;
   localparam int unsigned WORDS = 1 << WIDTH;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   mem_read_arbiter_if #(.N(N)) bus ();

   mem_read_arbiter #(.N(N), .WIDTH(WIDTH)) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
   );

   logic [31:0] mem [0:WORDS-1];
   assign bus.mem_dout = mem[bus.mem_addr[WIDTH+1:2]];

   int n_checks = 0;
   int n_err    = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s at %0t: got %h, required %h", name, $time, act, exp);
      end
   endtask

   // ---------------- transaction-level model ----------------
   function automatic bit bad_addr(input logic [31:0] a);
      return (a % 4 != 0) || (a >= 4 * WORDS);
   endfunction

   logic        m_if_gnt = 0, m_ls_gnt = 0, m_if_rv = 0, m_ls_rv = 0;
   logic        m_if_err = 0, m_ls_err = 0, m_busy = 0;
   logic [31:0] m_if_rdata = 0, m_ls_rdata = 0, m_addr = 0;
   logic        m_inflight = 0, m_owner_ls = 0, m_last_ls = 1;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_if_gnt <= 0; m_ls_gnt <= 0; m_if_rv <= 0; m_ls_rv <= 0;
         m_if_err <= 0; m_ls_err <= 0; m_busy <= 0;
         m_if_rdata <= 0; m_ls_rdata <= 0; m_addr <= 0;
         m_inflight <= 0; m_owner_ls <= 0; m_last_ls <= 1;
      end else begin
         m_if_gnt <= 0; m_ls_gnt <= 0; m_if_rv <= 0; m_ls_rv <= 0;
         if (m_inflight) begin
            // Second edge of an access: deliver the word to its owner.
            m_inflight <= 0;
            m_busy     <= 0;
            if (m_owner_ls) begin
               m_ls_rv    <= 1;
               m_ls_err   <= bad_addr(m_addr);
               m_ls_rdata <= bad_addr(m_addr) ? 32'h0 : mem[m_addr / 4];
            end else begin
               m_if_rv    <= 1;
               m_if_err   <= bad_addr(m_addr);
               m_if_rdata <= bad_addr(m_addr) ? 32'h0 : mem[m_addr / 4];
            end
         end else if (bus.if_req || bus.ls_req) begin
            automatic bit pick_ls = (bus.if_req && bus.ls_req) ? !m_last_ls : bus.ls_req;
            m_inflight <= 1;
            m_busy     <= 1;
            m_owner_ls <= pick_ls;
            m_last_ls  <= pick_ls;
            m_addr     <= pick_ls ? bus.ls_addr : bus.if_addr;
            m_if_gnt   <= !pick_ls;
            m_ls_gnt   <= pick_ls;
         end
      end
   end

   always @(negedge clk) begin
      check("if_gnt",    32'(bus.if_gnt),    32'(m_if_gnt));
      check("ls_gnt",    32'(bus.ls_gnt),    32'(m_ls_gnt));
      check("if_rvalid", 32'(bus.if_rvalid), 32'(m_if_rv));
      check("ls_rvalid", 32'(bus.ls_rvalid), 32'(m_ls_rv));
      check("if_err",    32'(bus.if_err),    32'(m_if_err));
      check("ls_err",    32'(bus.ls_err),    32'(m_ls_err));
      check("if_rdata",  bus.if_rdata,       m_if_rdata);
      check("ls_rdata",  bus.ls_rdata,       m_ls_rdata);
      check("mem_addr",  bus.mem_addr,       m_addr);
      check("busy",      32'(bus.busy),      32'(m_busy));
   end

   // Grant order log: 0 = IF, 1 = LS.
   int gnt_log [$];
   always @(negedge clk) begin
      if (bus.if_gnt) gnt_log.push_back(0);
      if (bus.ls_gnt) gnt_log.push_back(1);
   end

   // ---------------- stimulus helpers ----------------
   task automatic set_req(input bit is_ls, input logic v, input logic [31:0] a);
      if (is_ls) begin bus.ls_req = v; bus.ls_addr = a; end
      else       begin bus.if_req = v; bus.if_addr = a; end
   endtask

   task automatic wait_gnt(input bit is_ls);
      bit ok = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (is_ls ? bus.ls_gnt : bus.if_gnt) begin ok = 1; break; end
      end
      check(is_ls ? "ls_gnt_timeout" : "if_gnt_timeout", 32'(ok), 32'd1);
   endtask

   task automatic wait_rvalid(input bit is_ls);
      bit ok = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (is_ls ? bus.ls_rvalid : bus.if_rvalid) begin ok = 1; break; end
      end
      check(is_ls ? "ls_rvalid_timeout" : "if_rvalid_timeout", 32'(ok), 32'd1);
   endtask

   // One access: raise req, drop it at the edge ending the gnt cycle, await data.
   task automatic access(input bit is_ls, input logic [31:0] a);
      @(posedge clk); #1 set_req(is_ls, 1'b1, a);
      wait_gnt(is_ls);
      @(posedge clk); #1 set_req(is_ls, 1'b0, a);
      wait_rvalid(is_ls);
   endtask

   task automatic port_loop(input bit is_ls, input logic [31:0] a, input int times);
      for (int k = 0; k < times; k++) begin
         @(posedge clk); #1 set_req(is_ls, 1'b1, a);
         wait_gnt(is_ls);
         @(posedge clk); #1 set_req(is_ls, 1'b0, a);
      end
   endtask

   initial begin
      for (int i = 0; i < int'(WORDS); i++) mem[i] = 32'h5A00_0000 ^ (i * 32'h0101_0003);
      mem[3] = 32'hDEADBEEF;
      bus.if_req = 0; bus.if_addr = 0; bus.ls_req = 0; bus.ls_addr = 0;

      // Reset state.
      rst_n = 0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1;
      repeat (5) @(negedge clk);
      check("reset_mem_addr", bus.mem_addr, 32'h0);
      check("reset_busy", 32'(bus.busy), 32'd0);

      // Single fetch.
      access(0, 32'h0000_000C);
      check("fetch_rdata", bus.if_rdata, 32'hDEADBEEF);
      check("fetch_err", 32'(bus.if_err), 32'd0);
      check("fetch_ls_rdata_untouched", bus.ls_rdata, 32'h0);

      // Simultaneous requests from a fresh reset: IF wins the first tie.
      @(posedge clk); #1 rst_n = 0;
      @(posedge clk); #1 rst_n = 1;
      gnt_log.delete();
      fork
         port_loop(0, 32'h0, 2);
         port_loop(1, 32'h4, 2);
      join
      wait_rvalid(1);
      check("tie_grant_count", 32'(gnt_log.size()), 32'd4);
      if (gnt_log.size() == 4) begin
         check("tie_grant0_if", 32'(gnt_log[0]), 32'd0);
         check("tie_grant1_ls", 32'(gnt_log[1]), 32'd1);
         check("tie_grant2_if", 32'(gnt_log[2]), 32'd0);
         check("tie_grant3_ls", 32'(gnt_log[3]), 32'd1);
      end
      check("tie_if_rdata", bus.if_rdata, 32'h5A00_0000);
      check("tie_ls_rdata", bus.ls_rdata, 32'h5B01_0003);

      // Misaligned and out of range loads.
      access(1, 32'h0000_0006);
      check("misaligned_err", 32'(bus.ls_err), 32'd1);
      check("misaligned_rdata", bus.ls_rdata, 32'h0);
      access(1, 32'h0000_0800);
      check("range_err", 32'(bus.ls_err), 32'd1);
      check("range_rdata", bus.ls_rdata, 32'h0);
      check("range_mem_addr", bus.mem_addr, 32'h0000_0800);

      // Held fetch request: three grants in six edges.
      repeat (2) @(negedge clk);
      gnt_log.delete();
      @(posedge clk); #1 set_req(0, 1'b1, 32'h10);
      repeat (6) @(posedge clk);
      #1 set_req(0, 1'b0, 32'h10);
      repeat (3) @(negedge clk);
      check("held_grants", 32'(gnt_log.size()), 32'd3);
      check("held_rdata", bus.if_rdata, mem[4]);

      // Reset mid-access, then the next tie goes to IF.
      @(posedge clk); #1 set_req(0, 1'b1, 32'h8);
      wait_gnt(0);
      #2 rst_n = 0;
      set_req(0, 1'b0, 32'h8);
      #1;
      check("abort_busy", 32'(bus.busy), 32'd0);
      check("abort_if_gnt", 32'(bus.if_gnt), 32'd0);
      check("abort_if_rdata", bus.if_rdata, 32'h0);
      check("abort_mem_addr", bus.mem_addr, 32'h0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1;
      gnt_log.delete();
      repeat (3) @(negedge clk);
      check("abort_no_rvalid", 32'(gnt_log.size()), 32'd0);
      fork
         port_loop(0, 32'h8, 1);
         port_loop(1, 32'hC, 1);
      join
      wait_rvalid(1);
      check("post_reset_tie_count", 32'(gnt_log.size()), 32'd2);
      if (gnt_log.size() > 0) check("post_reset_tie_if", 32'(gnt_log[0]), 32'd0);
      check("post_reset_ls_rdata", bus.ls_rdata, 32'hDEADBEEF);
      repeat (2) @(negedge clk);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

   // Global time limit so the bench always ends.
   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish, required finish before 200000");
      $fatal(1);
   end

endmodule
